// File: rtl/aes_lite_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_lite_sched
// Purpose  : Shares one external AES-lite round unit between two requesters.
//            A round-robin arbiter picks a job. The block then runs
//            NUM_ROUNDS rounds through a go/ack handshake, keeps the running
//            8-bit state between rounds and returns the result tagged with
//            the id of the requester that owns it.
// Ports    : clk, rst (async, active high), flush (sync abort)
//            req0_*/req1_*  : valid/ready job inputs (data + key)
//            rnd_*          : round unit handshake (go pulse, state/key/idx
//                             out, ack/result in)
//            out_*          : result valid/ready with data, id and error flag
//            dbg_state/dbg_round : FSM encoding and current round index
// Revision : 1.0 - initial release
// ============================================================================
module aes_lite_sched #(
  parameter int NUM_ROUNDS = 10,  // legal 1..15
  parameter int TIMEOUT    = 15   // legal 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req0_key,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [7:0] req1_key,
  output logic       req1_ready,
  output logic       rnd_go,
  output logic [7:0] rnd_state,
  output logic [7:0] rnd_key,
  output logic [3:0] rnd_idx,
  input  logic       rnd_ack,
  input  logic [7:0] rnd_result,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic       out_err,
  input  logic       out_ready,
  output logic [3:0] dbg_state,
  output logic [3:0] dbg_round
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] st_q, st_d;
  logic [7:0] key_q, key_d;
  logic       id_q, id_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] round_q, round_d;
  logic [7:0] timer_q, timer_d;
  logic       err_q, err_d;

  logic       any_valid;
  logic       grant_id;
  logic       accept;

  // Single requester wins outright; on a tie the one not served last wins.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign accept    = (state_q == S_IDLE) & any_valid & ~flush;

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept &  grant_id;

  always_comb begin
    state_d      = state_q;
    st_d         = st_q;
    key_d        = key_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    round_d      = round_q;
    timer_d      = timer_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          st_d         = grant_id ? req1_data : req0_data;
          key_d        = grant_id ? req1_key  : req0_key;
          id_d         = grant_id;
          last_grant_d = grant_id;
          round_d      = 4'd0;
          err_d        = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack arriving on the expiry cycle takes precedence over timeout.
        if (rnd_ack) begin
          st_d = rnd_result;
          if (round_q == LAST_ROUND) begin
            state_d = S_OUT;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_ISSUE;
          end
        end else if (timer_q == TIMER_LAST) begin
          st_d    = 8'd0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything; arbitration history survives it.
    if (flush) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
      round_d = 4'd0;
      timer_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      st_q         <= 8'd0;
      key_q        <= 8'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      round_q      <= 4'd0;
      timer_q      <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      st_q         <= st_d;
      key_q        <= key_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      round_q      <= round_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

  assign rnd_go    = (state_q == S_ISSUE);
  assign rnd_state = st_q;
  assign rnd_key   = key_q;
  assign rnd_idx   = round_q;

  // Result fields are only presented while a result is actually offered.
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_valid ? st_q : 8'd0;
  assign out_id    = out_valid & id_q;
  assign out_err   = out_valid & err_q;

  assign dbg_state = {2'b00, state_q};
  assign dbg_round = round_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_lite_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_lite_sched
// Purpose  : Self-checking bench for aes_lite_sched (NUM_ROUNDS=2, TIMEOUT=4).
//            Round unit model: result = state ^ key ^ idx, acked on a
//            programmable wait cycle after go (0 = never).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_lite_sched;

  logic       clk, rst, flush;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req0_key, req1_data, req1_key;
  logic       rnd_go, rnd_ack;
  logic [7:0] rnd_state, rnd_key, rnd_result;
  logic [3:0] rnd_idx;
  logic       out_valid, out_id, out_err, out_ready;
  logic [7:0] out_data;
  logic [3:0] dbg_state, dbg_round;

  aes_lite_sched #(.NUM_ROUNDS(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_key(req0_key), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_key(req1_key), .req1_ready(req1_ready),
    .rnd_go(rnd_go), .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_idx(rnd_idx),
    .rnd_ack(rnd_ack), .rnd_result(rnd_result),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_err(out_err),
    .out_ready(out_ready), .dbg_state(dbg_state), .dbg_round(dbg_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // round unit model state
  int         wcnt   = 0;
  int         ack_at = 1;
  logic [7:0] m_res  = 8'h00;

  typedef struct {
    bit       port;
    bit [7:0] data;
    bit [7:0] key;
    int       ack;
    bit [7:0] exp_data;
    bit       exp_err;
    int       exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: the round model samples go before the edge, updates after it.
  task automatic tick();
    logic       g;
    logic       ack_prev;
    logic [7:0] res;
    g        = rnd_go;
    ack_prev = rnd_ack;
    res      = rnd_state ^ rnd_key ^ {4'b0000, rnd_idx};
    @(posedge clk);
    #1;
    if (g) begin
      wcnt  = 1;
      m_res = res;
    end else if (ack_prev) begin
      wcnt = 0;
    end else if (wcnt != 0) begin
      wcnt++;
    end
    rnd_ack    = (ack_at != 0) && (wcnt == ack_at);
    rnd_result = rnd_ack ? m_res : 8'hEE;
  endtask

  // Presents a job on port p and returns after the accept edge (in ISSUE).
  task automatic launch(input bit p, input logic [7:0] d, input logic [7:0] k);
    int n;
    if (p) begin req1_valid = 1'b1; req1_data = d; req1_key = k; end
    else   begin req0_valid = 1'b1; req0_data = d; req0_key = k; end
    #1;
    n = 0;
    while (!(p ? req1_ready : req0_ready) && n < 10) begin tick(); n++; end
    chk("accept_seen", p ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Counts cycles since the accept cycle until out_valid (bounded).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin tick(); lat++; end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    #1;
    tick();
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    int lat;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_key = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00; req1_key = 8'h00;
    rnd_ack = 1'b0; rnd_result = 8'h00;

    vecs[0] = '{0, 8'h3A, 8'h5C, 1, 8'h3B, 0, 5};
    vecs[1] = '{1, 8'h00, 8'h00, 1, 8'h01, 0, 5};
    vecs[2] = '{0, 8'hFF, 8'h0F, 1, 8'hFE, 0, 5};
    vecs[3] = '{1, 8'h80, 8'hAA, 1, 8'h81, 0, 5};
    vecs[4] = '{0, 8'h77, 8'h13, 0, 8'h00, 1, 6};   // never acked: timeout
    vecs[5] = '{1, 8'hC4, 8'h99, 4, 8'hC5, 0, 11};  // ack on expiry cycle wins
    vecs[6] = '{0, 8'h5A, 8'hA5, 3, 8'h5B, 0, 9};

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dbg_state", dbg_state, 0);
    chk("rst_rnd_go", rnd_go, 0);
    chk("rst_rnd_state", rnd_state, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    // both valid from reset: req0 first, then req1, then req0 again
    ack_at = 1;
    req0_valid = 1'b1; req0_data = 8'h10; req0_key = 8'h01;
    req1_valid = 1'b1; req1_data = 8'h20; req1_key = 8'h02;
    #1;
    chk("t2_first_r0_ready", req0_ready, 1);
    chk("t2_first_r1_ready", req1_ready, 0);
    tick();
    chk("t2_issue_state", dbg_state, 1);
    chk("t2_issue_go", rnd_go, 1);
    chk("t2_issue_key", rnd_key, 8'h01);
    chk("t2_issue_st", rnd_state, 8'h10);
    wait_out(lat);
    chk("t2_lat0", lat, 5);
    chk("t2_id0", out_id, 0);
    chk("t2_data0", out_data, 8'h11);
    // consumer stalls: result held, nobody accepted
    for (int i = 0; i < 6; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 8'h11);
      chk("t4_hold_r0", req0_ready, 0);
      chk("t4_hold_r1", req1_ready, 0);
      tick();
    end
    take();
    chk("t4_idle_state", dbg_state, 0);
    chk("t2_alt_r1_ready", req1_ready, 1);
    chk("t2_alt_r0_ready", req0_ready, 0);
    tick();
    wait_out(lat);
    chk("t2_lat1", lat, 5);
    chk("t2_id1", out_id, 1);
    chk("t2_data1", out_data, 8'h21);
    take();
    chk("t2_third_r0_ready", req0_ready, 1);
    chk("t2_third_r1_ready", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    // table-driven jobs
    foreach (vecs[i]) begin
      ack_at = vecs[i].ack;
      launch(vecs[i].port, vecs[i].data, vecs[i].key);
      wait_out(lat);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_id", i), out_id, vecs[i].port);
      chk($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      take();
    end

    // flush during WAIT of round 1, late ack ignored
    ack_at = 2;
    launch(0, 8'h42, 8'h10);
    tick(); tick(); tick();
    chk("t5_round1_issue", dbg_state, 1);
    chk("t5_round1_idx", dbg_round, 1);
    tick();
    chk("t5_wait_state", dbg_state, 2);
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    #1;
    chk("t5_flush_idle", dbg_state, 0);
    chk("t5_flush_round", dbg_round, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_out", out_valid, 0);
      chk("t5_stay_idle", dbg_state, 0);
      tick();
    end
    req0_valid = 1'b1; req0_data = 8'h42; req0_key = 8'h10;
    flush = 1'b1;
    #1;
    chk("t5_flush_blocks_ready", req0_ready, 0);
    flush = 1'b0;
    #1;
    chk("t5_ready_after_flush", req0_ready, 1);
    req0_valid = 1'b0;
    ack_at = 1;
    launch(0, 8'h42, 8'h10);
    wait_out(lat);
    chk("t5_next_data", out_data, 8'h43);
    chk("t5_next_err", out_err, 0);
    chk("t5_next_lat", lat, 5);
    take();

    // asynchronous reset while a result is offered
    launch(1, 8'h9C, 8'h33);
    wait_out(lat);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_id", out_id, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_id", out_id, 0);
    chk("t6_dbg_state", dbg_state, 0);
    chk("t6_rnd_state", rnd_state, 0);
    chk("t6_rnd_key", rnd_key, 0);
    wcnt = 0; rnd_ack = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t6_grant_r0", req0_ready, 1);
    chk("t6_grant_r1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
